prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 103 ++++++++++
 tb/tb_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Loader-side handshake and program-memory write bus for prog_loader.
interface prog_loader_if;
  logic       load_req;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       load_err;
  logic       busy;

  modport master (
    output load_req, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
  );

  modport slave (
    input  load_req, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: receives length, payload and checksum bytes, writes the payload to
// program memory and releases the CPU when the checksum matches.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [8:0]  len;
  logic [8:0]  cnt;
  logic [7:0]  sum;
  logic [15:0] timer;
  logic        ready;
  logic        we;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        run;
  logic        err;
  logic        accept;

  assign accept = ready & bus.byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      sum   <= '0;
      timer <= '0;
      ready <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      run   <= 1'b0;
      err   <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, RUN, ERR: begin
          if (bus.load_req) begin
            state <= LEN;
            ready <= 1'b1;
            run   <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            timer <= '0;
          end
        end
        LEN, DATA, CSUM: begin
          // An acceptance wins over a timeout expiring in the same cycle.
          if (accept) begin
            timer <= '0;
            if (state == LEN) begin
              len   <= (bus.byte_in == 8'h00) ? 9'd256 : {1'b0, bus.byte_in};
              state <= DATA;
            end else if (state == DATA) begin
              we    <= 1'b1;
              addr  <= cnt[7:0];
              wdata <= bus.byte_in;
              sum   <= sum + bus.byte_in;
              cnt   <= cnt + 9'd1;
              if (cnt == len - 9'd1) state <= CSUM;
            end else begin
              ready <= 1'b0;
              if (sum == bus.byte_in) begin
                state <= RUN;
                run   <= 1'b1;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end
          end else if (timer == TIMER_LAST) begin
            state <= ERR;
            err   <= 1'b1;
            ready <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = ready;
  assign bus.busy       = ready;
  assign bus.mem_we     = we;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;
  assign bus.cpu_run    = run;
  assign bus.load_err   = err;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as bytes are
// driven and matched against writes captured from the bus, including their cycle.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  prog_loader_if bus ();

  prog_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we !== 1'b0)
      obs_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, cyc: 32'(cyc)});
  end

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int first, input int count);
    for (int i = 0; i < bytes.size(); i++) begin
      bus.byte_in    = bytes[i];
      bus.byte_valid = 1'b1;
      if (i >= first && i < first + count)
        exp_q.push_back('{addr: 8'(i - first), data: bytes[i], cyc: 32'(cyc + 1)});
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] s[$];
    n_total++; if (bus.byte_ready !== 1'b0) $display("FAIL reset_byte_ready got=%b want=0", bus.byte_ready); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h00) $display("FAIL reset_mem_addr got=%h want=00", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata got=%h want=00", bus.mem_wdata); else n_pass++;
    n_total++; if (bus.cpu_run !== 1'b0) $display("FAIL reset_cpu_run got=%b want=0", bus.cpu_run); else n_pass++;
    n_total++; if (bus.load_err !== 1'b0) $display("FAIL reset_load_err got=%b want=0", bus.load_err); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
    rst = 1'b0;
    // Bytes offered in IDLE must be ignored.
    s = '{8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(s, 0, 0);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", bus.busy); else n_pass++;
    n_total++; if (obs_q.size() != 0) $display("FAIL idle_writes got=%0d want=0", obs_q.size()); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    wr_t e, o;
    pulse_load();
    n_total++; if (bus.byte_ready !== 1'b1) $display("FAIL basic_len_ready got=%b want=1", bus.byte_ready); else n_pass++;
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_bytes(s, 1, 3);
    n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL basic_cpu_run got=%b want=1", bus.cpu_run); else n_pass++;
    n_total++; if (bus.load_err !== 1'b0) $display("FAIL basic_load_err got=%b want=0", bus.load_err); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy got=%b want=0", bus.busy); else n_pass++;
    // Bytes offered in RUN must be ignored.
    s = '{8'h01, 8'h02, 8'h03};
    send_bytes(s, 0, 0);
    @(negedge clk);
    n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL basic_run_hold got=%b want=1", bus.cpu_run); else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL basic_write missing got=none want=%h/%h@%0d", e.addr, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_write got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL basic_extra_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_basic done");
  endtask

  task automatic test_csum_err();
    logic [7:0] s[$];
    wr_t e, o;
    pulse_load();
    s = '{8'h02, 8'hA0, 8'hB0, 8'h00};
    send_bytes(s, 1, 2);
    n_total++; if (bus.load_err !== 1'b1) $display("FAIL csum_load_err got=%b want=1", bus.load_err); else n_pass++;
    n_total++; if (bus.cpu_run !== 1'b0) $display("FAIL csum_cpu_run got=%b want=0", bus.cpu_run); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL csum_busy got=%b want=0", bus.busy); else n_pass++;
    pulse_load();
    n_total++; if (bus.load_err !== 1'b0) $display("FAIL csum_err_clear got=%b want=0", bus.load_err); else n_pass++;
    s = '{8'h01, 8'h05, 8'h05};
    send_bytes(s, 1, 1);
    n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL csum_retry_run got=%b want=1", bus.cpu_run); else n_pass++;
    n_total++; if (bus.load_err !== 1'b0) $display("FAIL csum_retry_err got=%b want=0", bus.load_err); else n_pass++;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL csum_write missing got=none want=%h/%h@%0d", e.addr, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL csum_write got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL csum_extra_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_csum_err done");
  endtask

  task automatic test_len256();
    logic [7:0] s[$];
    wr_t e, o;
    wr_t last;
    int  nw;
    nw = 0;
    last = '0;
    pulse_load();
    s.push_back(8'h00);
    repeat (256) s.push_back(8'h01);
    s.push_back(8'h00);
    send_bytes(s, 1, 256);
    n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL len256_cpu_run got=%b want=1", bus.cpu_run); else n_pass++;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        n_total++;
        $display("FAIL len256_write missing got=none want=%h/%h@%0d", e.addr, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        n_total++;
        if (o !== e) $display("FAIL len256_write got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        else n_pass++;
        last = o;
        nw++;
      end
    end
    n_total++; if (last.addr !== 8'hFF || nw != 256) $display("FAIL len256_last got=%h/%0d want=ff/256", last.addr, nw); else n_pass++;
    n_total++; if (obs_q.size() != 0) $display("FAIL len256_extra_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_len256 done");
  endtask

  task automatic test_timeout();
    wr_t e, o;
    int  c;
    // Expiry: no byte after AA.
    pulse_load();
    bus.byte_in = 8'h02; bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_in = 8'hAA;
    c = cyc;
    exp_q.push_back('{addr: 8'h00, data: 8'hAA, cyc: 32'(c + 1)});
    @(negedge clk);
    bus.byte_valid = 1'b0;
    while (cyc < c + 8) @(negedge clk);
    n_total++; if (bus.busy !== 1'b1 || bus.load_err !== 1'b0) $display("FAIL timeout_early got=busy%b/err%b want=busy1/err0", bus.busy, bus.load_err); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.load_err !== 1'b1) $display("FAIL timeout_err got=%b want=1", bus.load_err); else n_pass++;
    n_total++; if (bus.byte_ready !== 1'b0) $display("FAIL timeout_ready got=%b want=0", bus.byte_ready); else n_pass++;
    // A byte on the expiry cycle is accepted instead.
    pulse_load();
    bus.byte_in = 8'h02; bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_in = 8'hAA;
    c = cyc;
    exp_q.push_back('{addr: 8'h00, data: 8'hAA, cyc: 32'(c + 1)});
    @(negedge clk);
    bus.byte_valid = 1'b0;
    while (cyc < c + 8) @(negedge clk);
    bus.byte_in = 8'hBB; bus.byte_valid = 1'b1;
    exp_q.push_back('{addr: 8'h01, data: 8'hBB, cyc: 32'(c + 9)});
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_total++; if (bus.busy !== 1'b1 || bus.load_err !== 1'b0) $display("FAIL timeout_accept got=busy%b/err%b want=busy1/err0", bus.busy, bus.load_err); else n_pass++;
    bus.byte_in = 8'h65; bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_total++; if (bus.cpu_run !== 1'b1) $display("FAIL timeout_run got=%b want=1", bus.cpu_run); else n_pass++;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL timeout_write missing got=none want=%h/%h@%0d", e.addr, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL timeout_write got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL timeout_extra_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    pulse_load();
    s = '{8'h03};
    send_bytes(s, 0, 0);
    bus.byte_in = 8'h11; bus.byte_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    bus.byte_valid = 1'b0;
    #1;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rstmid_mem_we got=%b want=0", bus.mem_we); else n_pass++;
    n_total++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) $display("FAIL rstmid_bus got=%h want=0000", {bus.mem_addr, bus.mem_wdata}); else n_pass++;
    n_total++; if ({bus.byte_ready, bus.busy, bus.cpu_run, bus.load_err} !== 4'b0000) $display("FAIL rstmid_flags got=%b want=0000", {bus.byte_ready, bus.busy, bus.cpu_run, bus.load_err}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    s = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(s, 0, 0);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_idle got=%b want=0", bus.busy); else n_pass++;
    n_total++; if (obs_q.size() != 0) $display("FAIL rstmid_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    wr_t e, o;
    pulse_load();
    s = '{8'h03, 8'h11};
    send_bytes(s, 1, 1);
    // load_req alongside a payload byte must not restart the session.
    bus.load_req = 1'b1;
    bus.byte_in = 8'h22; bus.byte_valid = 1'b1;
    exp_q.push_back('{addr: 8'h01, data: 8'h22, cyc: 32'(cyc + 1)});
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.byte_in = 8'h33;
    exp_q.push_back('{addr: 8'h02, data: 8'h33, cyc: 32'(cyc + 1)});
    @(negedge clk);
    bus.byte_in = 8'h66;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_total++; if (bus.cpu_run !== 1'b1 || bus.load_err !== 1'b0) $display("FAIL b2b_result got=run%b/err%b want=run1/err0", bus.cpu_run, bus.load_err); else n_pass++;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL b2b_write missing got=none want=%h/%h@%0d", e.addr, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_write got=%h/%h@%0d want=%h/%h@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL b2b_extra_writes got=%0d want=0", obs_q.size()); else n_pass++;
    obs_q.delete();
    $display("test_back_to_back done");
  endtask

  initial begin
    bus.load_req   = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_csum_err();
    test_len256();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
